// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS pipeline control: sequencer states,
// stall-need codes, opcodes and the NOP instruction word.
package mips_pkg;

  typedef enum logic [1:0] {
    ST_RUN    = 2'd0,
    ST_HAZ    = 2'd1,
    ST_HALTED = 2'd2
  } hcu_state_e;

  localparam logic [1:0] NEED_NONE = 2'd0;
  localparam logic [1:0] NEED_ONE  = 2'd1;
  localparam logic [1:0] NEED_TWO  = 2'd2;

  localparam logic [5:0] OP_HALT = 6'b111111;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_BNE  = 6'b000101;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

endpackage

// File: rtl/hazard_detect.sv
// Combinational stall-need computation: how many cycles the instruction in ID
// must wait before its source operands can be forwarded.
module hazard_detect
  import mips_pkg::*;
#(
  parameter int SIZE_REG_DIR = 5
) (
  input  logic [SIZE_REG_DIR-1:0] i_rs_id,
  input  logic [SIZE_REG_DIR-1:0] i_rt_id,
  input  logic                    i_uses_rt_id,
  input  logic                    i_is_branch_id,
  input  logic [SIZE_REG_DIR-1:0] i_rd_id_ex,
  input  logic                    i_mem_read_id_ex,
  input  logic                    i_reg_wr_id_ex,
  input  logic [SIZE_REG_DIR-1:0] i_rd_ex_mem,
  input  logic                    i_mem_read_ex_mem,
  output logic [1:0]              o_need
);

  logic match_id_ex;
  logic match_ex_mem;

  // $0 is hardwired to zero, so it never creates a dependency.
  function automatic logic op_match(input logic [SIZE_REG_DIR-1:0] rd,
                                    input logic [SIZE_REG_DIR-1:0] rs,
                                    input logic [SIZE_REG_DIR-1:0] rt,
                                    input logic                    uses_rt);
    return (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
  endfunction

  always_comb begin
    match_id_ex  = op_match(i_rd_id_ex, i_rs_id, i_rt_id, i_uses_rt_id);
    match_ex_mem = op_match(i_rd_ex_mem, i_rs_id, i_rt_id, i_uses_rt_id);
    o_need       = NEED_NONE;
    if (i_is_branch_id && i_mem_read_id_ex && match_id_ex) begin
      o_need = NEED_TWO;
    end else if (i_is_branch_id &&
                 ((i_reg_wr_id_ex && match_id_ex) || (i_mem_read_ex_mem && match_ex_mem))) begin
      o_need = NEED_ONE;
    end else if (i_mem_read_id_ex && match_id_ex) begin
      o_need = NEED_ONE;
    end
  end

endmodule

// File: rtl/hazard_control_unit.sv
// Pipeline sequencer: stalls, bubbles, flushes, HALT latch and debug freeze.
// Optional saturating stall/flush statistics when HAZARD_STATS_EN is defined.
module hazard_control_unit
  import mips_pkg::*;
#(
  parameter int SIZE_REG_DIR = 5,
  parameter int STATS_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [SIZE_REG_DIR-1:0] i_rs_id,
  input  logic [SIZE_REG_DIR-1:0] i_rt_id,
  input  logic                    i_uses_rt_id,
  input  logic                    i_is_branch_id,
  input  logic                    i_halt_id,
  input  logic                    i_take_branch,
  input  logic [SIZE_REG_DIR-1:0] i_rd_id_ex,
  input  logic                    i_mem_read_id_ex,
  input  logic                    i_reg_wr_id_ex,
  input  logic [SIZE_REG_DIR-1:0] i_rd_ex_mem,
  input  logic                    i_mem_read_ex_mem,
  input  logic                    i_step_mode,
  input  logic                    i_step,
  output logic                    o_freeze,
  output logic                    o_stall_pc,
  output logic                    o_stall_if_id,
  output logic                    o_bubble_id_ex,
  output logic                    o_flush_if_id,
  output logic                    o_halted,
  output logic [STATS_WIDTH-1:0]  o_stall_count,
  output logic [STATS_WIDTH-1:0]  o_flush_count
);

  hcu_state_e state_q, state_d;
  logic [1:0] cnt_q, cnt_d;
  logic [1:0] need;
  logic       frozen;
  logic       stall, bubble, flush, halted;

  hazard_detect #(.SIZE_REG_DIR(SIZE_REG_DIR)) u_detect (
    .i_rs_id           (i_rs_id),
    .i_rt_id           (i_rt_id),
    .i_uses_rt_id      (i_uses_rt_id),
    .i_is_branch_id    (i_is_branch_id),
    .i_rd_id_ex        (i_rd_id_ex),
    .i_mem_read_id_ex  (i_mem_read_id_ex),
    .i_reg_wr_id_ex    (i_reg_wr_id_ex),
    .i_rd_ex_mem       (i_rd_ex_mem),
    .i_mem_read_ex_mem (i_mem_read_ex_mem),
    .o_need            (need)
  );

  assign frozen = i_step_mode & ~i_step;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stall   = 1'b0;
    bubble  = 1'b0;
    flush   = 1'b0;
    halted  = 1'b0;
    unique case (state_q)
      ST_RUN: begin
        // Hazard wins over halt and flush: branch operands are not valid yet.
        if (need != NEED_NONE) begin
          stall   = 1'b1;
          bubble  = 1'b1;
          cnt_d   = need - 2'd1;
          state_d = (cnt_d != 2'd0) ? ST_HAZ : ST_RUN;
        end else if (i_halt_id) begin
          bubble  = 1'b1;
          state_d = ST_HALTED;
        end else if (i_take_branch) begin
          flush = 1'b1;
        end
      end
      ST_HAZ: begin
        stall  = 1'b1;
        bubble = 1'b1;
        cnt_d  = cnt_q - 2'd1;
        if (cnt_d == 2'd0) state_d = ST_RUN;
      end
      ST_HALTED: begin
        halted = 1'b1;
        stall  = 1'b1;
        bubble = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    if (frozen) begin
      state_d = state_q;
      cnt_d   = cnt_q;
      stall   = 1'b0;
      bubble  = 1'b0;
      flush   = 1'b0;
    end
    if (rst) begin
      stall  = 1'b0;
      bubble = 1'b0;
      flush  = 1'b0;
      halted = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign o_freeze       = frozen;
  assign o_stall_pc     = stall;
  assign o_stall_if_id  = stall;
  assign o_bubble_id_ex = bubble;
  assign o_flush_if_id  = flush;
  assign o_halted       = halted;

`ifdef HAZARD_STATS_EN
  logic [STATS_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [STATS_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

  // stall is already cleared while frozen; HALTED cycles are not hazard stalls.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (state_q != ST_HALTED) && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush && (flush_cnt_q != '1)) flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign o_stall_count = stall_cnt_q;
  assign o_flush_count = flush_cnt_q;
`else
  assign o_stall_count = '0;
  assign o_flush_count = '0;
`endif

endmodule

// File: doc/hazard_control_unit.md
Name: hazard_control_unit

Overview:
Pipeline sequencer for the 5-stage MIPS core. It sits beside instruction_decode and issues the control signals for the PC, IF/ID and ID/EX registers:
- stalls the PC and IF/ID on load-use and branch-operand hazards;
- inserts bubbles into ID/EX;
- flushes IF/ID on a taken branch or jump;
- latches HALT;
- freezes the whole pipeline for debug single-step.

Parameters:
SIZE_REG_DIR, 5, register-address width
STATS_WIDTH, 32, width of the hazard statistics counters (used only with HAZARD_STATS_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high
i_rs_id  in  SIZE_REG_DIR  rs field of the instruction in ID
i_rt_id  in  SIZE_REG_DIR  rt field of the instruction in ID
i_uses_rt_id  in  1  ID instruction reads rt as a source
i_is_branch_id  in  1  ID instruction is BEQ/BNE/JR/JALR (operands compared or used in ID)
i_halt_id  in  1  ID instruction is HALT
i_take_branch  in  1  branch/jump resolved taken in ID (i_jump_brch of the decode stage)
i_rd_id_ex  in  SIZE_REG_DIR  destination register in ID/EX
i_mem_read_id_ex  in  1  ID/EX holds a load
i_reg_wr_id_ex  in  1  ID/EX writes a register
i_rd_ex_mem  in  SIZE_REG_DIR  destination register in EX/MEM
i_mem_read_ex_mem  in  1  EX/MEM holds a load
i_step_mode  in  1  debug single-step mode enable
i_step  in  1  one-cycle pulse: advance the pipeline one cycle in step mode
o_freeze  out  1  hold every pipeline register and the PC
o_stall_pc  out  1  hold the PC
o_stall_if_id  out  1  hold IF/ID
o_bubble_id_ex  out  1  load a NOP into ID/EX
o_flush_if_id  out  1  load a NOP into IF/ID
o_halted  out  1  core halted
o_stall_count  out  STATS_WIDTH  cycles spent stalled (optional feature)
o_flush_count  out  STATS_WIDTH  flushes issued (optional feature)

Behaviour:
- Single clock domain: clk. Synchronous, active-high reset: rst.
- FSM states: RUN, HAZ, HALTED. Register cnt is 2 bits.
- Reset: state RUN, cnt 0, counters 0. All outputs 0, except o_freeze = i_step_mode (combinational).
- Freeze:
  - o_freeze = i_step_mode & ~i_step, in every state.
  - While frozen, the FSM, cnt and counters hold, and o_stall_pc, o_stall_if_id, o_bubble_id_ex and o_flush_if_id are forced to 0 (the freeze dominates).
- Register $0 never causes a hazard.
- Operand match m(rd) = (rd != 0) & (rd == i_rs_id | (i_uses_rt_id & rd == i_rt_id)).
- Stall need n, combinational, evaluated in RUN only:
  - 2 if i_is_branch_id & i_mem_read_id_ex & m(i_rd_id_ex);
  - else 1 if i_is_branch_id & ((i_reg_wr_id_ex & m(i_rd_id_ex)) | (i_mem_read_ex_mem & m(i_rd_ex_mem)));
  - else 1 if i_mem_read_id_ex & m(i_rd_id_ex);
  - else 0.
- RUN, not frozen:
  - if i_halt_id and n == 0: go to HALTED next cycle; o_bubble_id_ex = 1 this cycle.
  - if n > 0: o_stall_pc = o_stall_if_id = o_bubble_id_ex = 1 this cycle (zero latency). Set cnt <= n-1; go to HAZ if n-1 > 0, otherwise stay in RUN.
  - if n == 0 and i_take_branch: o_flush_if_id = 1 for exactly one cycle.
  - Priority: hazard > halt > flush. i_take_branch is ignored whenever n > 0, because the operands are not yet valid.
- HAZ, not frozen:
  - stall and bubble outputs = 1; inputs are not re-evaluated;
  - cnt decrements; return to RUN when cnt reaches 0;
  - i_take_branch is ignored.
- HALTED: o_halted = 1; o_stall_pc = o_stall_if_id = 1; o_bubble_id_ex = 1 (drains the pipeline). Exit only via rst.
- Reset mid-HAZ or in HALTED returns to RUN on the next edge; no residual stall.

Optional Feature:
Macro HAZARD_STATS_EN.
- Defined: o_stall_count increments on every non-frozen cycle with o_stall_pc = 1 while not HALTED. o_flush_count increments on every o_flush_if_id. Both saturate at all-ones and clear on rst.
- Undefined: both ports remain and are tied to 0; no counter flops are inferred.

Decomposition:
- Shared package mips_pkg holds:
  - state encodings: ST_RUN = 2'd0, ST_HAZ = 2'd1, ST_HALTED = 2'd2;
  - opcode constants OP_HALT, OP_BEQ, OP_BNE;
  - NOP instruction word 32'h0.
- One sub-module: hazard_detect, the purely combinational computation of n (the stall need), kept separate from the FSM for unit testing.

Test Plan:
1. LW $2 in ID/EX (mem_read=1, rd=2); ADD reads rs=2 in ID -> o_stall_pc / o_stall_if_id / o_bubble_id_ex high for exactly 1 cycle, then 0.
2. LW $3 in ID/EX; BEQ with rs=3, is_branch=1, i_take_branch=1 -> stalls for 2 cycles with o_flush_if_id=0; after the HAZ state exits, with the load no longer in ID/EX or EX/MEM and i_take_branch=1, o_flush_if_id=1 for 1 cycle.
3. LW $0 in ID/EX; consumer reads rs=0 -> no stall (all outputs 0).
4. i_halt_id=1, no hazard -> o_halted=1 from the next cycle and held 100 cycles; rst pulse -> o_halted=0, state RUN.
5. i_step_mode=1 during a 2-cycle HAZ with i_step pulsed every 3rd cycle -> o_freeze low only on step cycles; HAZ lasts exactly 2 stepped cycles.
6. HAZARD_STATS_EN: 4 single stalls + 3 flushes -> o_stall_count=4, o_flush_count=3. With STATS_WIDTH=2 and 5 stalls -> o_stall_count saturates at 3.
